// File: rtl/bcd_pkg.sv
// Shared types and helpers for the shift-and-add-3 binary-to-BCD converter.
// Holds the FSM states, the blank segment code and the seven-segment table.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decimal digits needed for a width-bit unsigned value: ceil(width*log10(2)).
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

    // Active-low segments, bit0=a ... bit6=g; codes above 9 show blank.
    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// Single-digit BCD to active-low seven-segment decoder.
// A blank request overrides the digit and turns every segment off.
module bcd_seg7_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the digit pattern.
    always_comb begin
        seg = blank ? SEG_BLANK : seg7(digit);
    end

endmodule

// File: rtl/bcd_shift_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock,
// with optional signed input, registered result and leading-zero blanking.
module bcd_shift_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int SIGNED   = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (BIN_W < 2) begin : g_bin_w_check
        $error("bcd_shift_converter: BIN_W must be at least 2");
    end

    if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
        $error("bcd_shift_converter: DIGITS too small for BIN_W");
    end

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               neg_pending_q, neg_pending_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]        adj;
    logic [BCD_W+BIN_W-1:0]  cat;
    logic                    neg_load;
    logic [DIGITS-1:0]       blank;
    logic                    zero_run;

    // Next-state: load on start, add-3 then shift while converting.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        scratch_d     = scratch_q;
        count_d       = count_q;
        neg_pending_d = neg_pending_q;
        bcd_d         = bcd_q;
        neg_d         = neg_q;
        done_d        = 1'b0;
        neg_load      = 1'b0;
        adj           = scratch_q;

        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        cat = {adj, shreg_q} << 1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    neg_load      = (SIGNED != 0) && bin_in[BIN_W-1];
                    shreg_d       = neg_load ? -bin_in : bin_in;
                    neg_pending_d = neg_load;
                    scratch_d     = '0;
                    count_d       = CNT_INIT;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = cat[BCD_W+BIN_W-1:BIN_W];
                shreg_d   = cat[BIN_W-1:0];
                count_d   = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    bcd_d   = cat[BCD_W+BIN_W-1:BIN_W];
                    neg_d   = neg_pending_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            scratch_q     <= '0;
            count_q       <= '0;
            neg_pending_q <= 1'b0;
            bcd_q         <= '0;
            neg_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            scratch_q     <= scratch_d;
            count_q       <= count_d;
            neg_pending_q <= neg_pending_d;
            bcd_q         <= bcd_d;
            neg_q         <= neg_d;
            done_q        <= done_d;
        end
    end

    // Prefix-zero chain from the top digit down; digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (bcd_q[4*k +: 4] == 4'd0);
            blank[k] = (BLANK_LZ != 0) && (k != 0) && zero_run;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
        bcd_seg7_decoder u_dec (
            .digit (bcd_q[4*gi +: 4]),
            .blank (blank[gi]),
            .seg   (seg_out[7*gi +: 7])
        );
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign neg     = neg_q;

endmodule

// File: tb/tb_bcd_shift_converter.sv
// Directed bench for bcd_shift_converter in three configurations:
// 8-bit unsigned blanked, 8-bit signed unblanked, 16-bit unsigned.
module tb_bcd_shift_converter;

    typedef struct {
        logic [63:0] bcd;
        logic        neg;
    } exp_t;

    logic        CLOCK_50;
    logic        RESET_N;

    logic        start_u, busy_u, done_u, neg_u;
    logic [7:0]  bin_u;
    logic [11:0] bcd_u;
    logic [20:0] seg_u;

    logic        start_s, busy_s, done_s, neg_s;
    logic [7:0]  bin_s;
    logic [11:0] bcd_s;
    logic [20:0] seg_s;

    logic        start_w, busy_w, done_w, neg_w;
    logic [15:0] bin_w;
    logic [19:0] bcd_w;
    logic [34:0] seg_w;

    exp_t sb[$];
    int   passed;
    int   total;

    bcd_shift_converter #(
        .BIN_W(8), .DIGITS(3), .SIGNED(0), .BLANK_LZ(1)
    ) dut_u (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .start    (start_u),
        .bin_in   (bin_u),
        .busy     (busy_u),
        .done     (done_u),
        .bcd_out  (bcd_u),
        .neg      (neg_u),
        .seg_out  (seg_u)
    );

    bcd_shift_converter #(
        .BIN_W(8), .DIGITS(3), .SIGNED(1), .BLANK_LZ(0)
    ) dut_s (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .start    (start_s),
        .bin_in   (bin_s),
        .busy     (busy_s),
        .done     (done_s),
        .bcd_out  (bcd_s),
        .neg      (neg_s),
        .seg_out  (seg_s)
    );

    bcd_shift_converter #(
        .BIN_W(16), .DIGITS(5), .SIGNED(0), .BLANK_LZ(1)
    ) dut_w (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .start    (start_w),
        .bin_in   (bin_w),
        .busy     (busy_w),
        .done     (done_w),
        .bcd_out  (bcd_w),
        .neg      (neg_w),
        .seg_out  (seg_w)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_u;
            1:       return done_s;
            default: return done_w;
        endcase
    endfunction

    function automatic logic [63:0] bcd_of(input int sel);
        case (sel)
            0:       return {52'd0, bcd_u};
            1:       return {52'd0, bcd_s};
            default: return {44'd0, bcd_w};
        endcase
    endfunction

    function automatic logic neg_of(input int sel);
        case (sel)
            0:       return neg_u;
            1:       return neg_s;
            default: return neg_w;
        endcase
    endfunction

    task automatic drop_start(input int sel);
        case (sel)
            0:       start_u = 1'b0;
            1:       start_s = 1'b0;
            default: start_w = 1'b0;
        endcase
    endtask

    // Waits for done on one instance, then checks latency and the
    // scoreboard entry. Latency is counted in falling edges seen.
    task automatic wait_done(input int sel, input bit hold,
                             input int exp_n, input string tag);
        int   n;
        exp_t e;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CLOCK_50);
            if (!hold) drop_start(sel);
            if (done_of(sel)) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            total++;
            $error("FAIL %s_timeout: observed no done, expected done", tag);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            total++;
            $error("FAIL %s_sb: observed done, expected none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"}, 64'(n), 64'(exp_n));
            chk({tag, "_bcd"}, bcd_of(sel), e.bcd);
            chk({tag, "_neg"}, {63'd0, neg_of(sel)}, {63'd0, e.neg});
        end
    endtask

    initial begin
        int dn;
        passed  = 0;
        total   = 0;
        RESET_N = 1'b0;
        start_u = 1'b0;
        start_s = 1'b0;
        start_w = 1'b0;
        bin_u   = '0;
        bin_s   = '0;
        bin_w   = '0;

        // Reset state
        repeat (2) @(negedge CLOCK_50);
        chk("rst_busy", {63'd0, busy_u}, 64'd0);
        chk("rst_done", {63'd0, done_u}, 64'd0);
        chk("rst_bcd", {52'd0, bcd_u}, 64'd0);
        chk("rst_neg", {63'd0, neg_u}, 64'd0);
        chk("rst_seg_u", {43'd0, seg_u}, {43'd0, 7'h7F, 7'h7F, 7'h40});
        chk("rst_seg_s", {43'd0, seg_s}, {43'd0, 7'h40, 7'h40, 7'h40});
        chk("rst_seg_w", {29'd0, seg_w},
            {29'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        RESET_N = 1'b1;
        @(negedge CLOCK_50);

        // 255: full-scale unsigned
        sb.push_back('{64'h255, 1'b0});
        bin_u   = 8'd255;
        start_u = 1'b1;
        @(negedge CLOCK_50);
        start_u = 1'b0;
        chk("u255_busy", {63'd0, busy_u}, 64'd1);
        wait_done(0, 1'b0, 8, "u255");
        chk("u255_seg", {43'd0, seg_u}, {43'd0, 7'h24, 7'h12, 7'h12});
        @(negedge CLOCK_50);
        chk("u255_pulse", {63'd0, done_u}, 64'd0);
        chk("u255_hold", {52'd0, bcd_u}, 64'h255);
        chk("u255_idle", {63'd0, busy_u}, 64'd0);

        // 7 and 0: leading-zero blanking
        sb.push_back('{64'h007, 1'b0});
        bin_u   = 8'd7;
        start_u = 1'b1;
        wait_done(0, 1'b0, 9, "u7");
        chk("u7_seg", {43'd0, seg_u}, {43'd0, 7'h7F, 7'h7F, 7'h78});
        sb.push_back('{64'h000, 1'b0});
        bin_u   = 8'd0;
        start_u = 1'b1;
        wait_done(0, 1'b0, 9, "u0");
        chk("u0_seg", {43'd0, seg_u}, {43'd0, 7'h7F, 7'h7F, 7'h40});

        // Start held high; bin_in changes mid-conversion
        sb.push_back('{64'h200, 1'b0});
        bin_u   = 8'd200;
        start_u = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        bin_u = 8'd99;
        wait_done(0, 1'b1, 6, "held1");
        sb.push_back('{64'h099, 1'b0});
        wait_done(0, 1'b0, 9, "held2");

        // Asynchronous reset during shift 4 of a 255 conversion
        bin_u   = 8'd255;
        start_u = 1'b1;
        @(negedge CLOCK_50);
        start_u = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy_u}, 64'd0);
        chk("mid_rst_done", {63'd0, done_u}, 64'd0);
        chk("mid_rst_bcd", {52'd0, bcd_u}, 64'd0);
        chk("mid_rst_seg", {43'd0, seg_u}, {43'd0, 7'h7F, 7'h7F, 7'h40});
        dn = 0;
        repeat (3) begin
            @(negedge CLOCK_50);
            dn += int'(done_u);
        end
        RESET_N = 1'b1;
        repeat (10) begin
            @(negedge CLOCK_50);
            dn += int'(done_u);
        end
        chk("mid_rst_nodone", 64'(dn), 64'd0);
        sb.push_back('{64'h042, 1'b0});
        bin_u   = 8'd42;
        start_u = 1'b1;
        wait_done(0, 1'b0, 9, "u42");

        // Signed inputs
        sb.push_back('{64'h128, 1'b1});
        bin_s   = 8'h80;
        start_s = 1'b1;
        wait_done(1, 1'b0, 9, "s80");
        sb.push_back('{64'h001, 1'b1});
        bin_s   = 8'hFF;
        start_s = 1'b1;
        wait_done(1, 1'b0, 9, "sFF");
        chk("sFF_seg", {43'd0, seg_s}, {43'd0, 7'h40, 7'h40, 7'h79});
        sb.push_back('{64'h127, 1'b0});
        bin_s   = 8'h7F;
        start_s = 1'b1;
        wait_done(1, 1'b0, 9, "s7F");

        // 16-bit back-to-back conversions
        sb.push_back('{64'h65535, 1'b0});
        bin_w   = 16'hFFFF;
        start_w = 1'b1;
        wait_done(2, 1'b1, 17, "wFFFF");
        sb.push_back('{64'h12345, 1'b0});
        bin_w = 16'd12345;
        wait_done(2, 1'b0, 17, "w12345");
        chk("w12345_seg", {29'd0, seg_w},
            {29'd0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        @(negedge CLOCK_50);
        chk("w_idle", {63'd0, busy_w}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_shift_converter.md
# bcd_shift_converter

Parametrised, sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock, with a start/busy/done handshake. It replaces the single-cycle, fixed 8-bit switch-to-HEX path. It sits between any binary source (switches, counters, ALU results) and the per-digit seven-segment outputs. It adds optional signed input handling and leading-zero blanking.

## Interface
- BIN_W, 8: binary input width (≥2).
- DIGITS, 3: BCD digit count. Must be ≥ ceil(BIN_W·log10 2); elaboration fails otherwise.
- SIGNED, 0: 1 = `bin_in` is two's complement; its magnitude is converted and `neg` is reported.
- BLANK_LZ, 1: 1 = leading-zero digits drive the blank segment code.
- CLOCK_50  in  1  sole clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only while idle.
- bin_in  in  BIN_W  value to convert; captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when `bcd_out` updates.
- bcd_out  out  4·DIGITS  registered result; digit k is bits [4k+3:4k]; holds until the next done.
- neg  out  1  sign of the last result (always 0 when SIGNED=0).
- seg_out  out  7·DIGITS  active-low segments per digit, bit0=a … bit6=g, decoded from `bcd_out`.

## Operation
- States: IDLE, SHIFT.
- IDLE with start=1:
  - Capture `bin_in` into the shift register. If SIGNED and the MSB is set, load its two's-complement negation and set `neg_pending`.
  - Clear the scratch BCD register; set count=BIN_W; go to SHIFT; busy=1.
- SHIFT, every cycle:
  - Each scratch digit ≥5 gets +3 (4-bit, no carry between digits).
  - Then shift {scratch, shift reg} left by 1; count decrements.
- On the shift with count==1:
  - Write the shifted scratch directly into `bcd_out`, and `neg_pending` into `neg`.
  - Pulse done; busy=0; return to IDLE.
- start while busy: ignored; `bin_in` changes during SHIFT have no effect.
- Most negative signed input (−2^(BIN_W−1)): its magnitude is held as an unsigned BIN_W value and converts correctly.
- Segment decode is combinational from `bcd_out`:
  - Codes 10–15 are unreachable; they decode to blank (7'h7F).
  - Blanking: digit k (k>0) is blank when BLANK_LZ=1 and digits k..DIGITS−1 are all zero. Digit 0 is never blanked.

## Timing
- Start accepted at edge E0. Shifts occur at E1…E_BIN_W. done=1 and `bcd_out` is valid in the cycle after E_BIN_W.
- Latency: BIN_W cycles from the accepted start to done.
- Throughput: one conversion per BIN_W+1 cycles. A start held high in the done cycle is accepted at the next edge.
- Reset values: busy=0, done=0, bcd_out=0, neg=0, state=IDLE.
  - seg_out after reset shows "0" on digit 0 (7'b1000000). Other digits are blank if BLANK_LZ=1, otherwise "0".
- Reset asserted mid-conversion aborts immediately and asynchronously: no done pulse, `bcd_out` cleared. After release, the first start behaves normally.

## Structure
- Package `bcd_pkg`:
  - state enum (IDLE, SHIFT).
  - `SEG_BLANK` = 7'h7F.
  - function `min_digits(width)` for the elaboration check.
  - function `seg7(bcd)` returning the active-low pattern.
- Sub-module `bcd_seg7_decoder`: one 4-bit digit plus a blank input → 7 segments. Instantiated DIGITS times via generate, with blank computed by a prefix-zero chain in the parent.

## Test plan
- BIN_W=8, unsigned, bin_in=255 → done after exactly 8 cycles; bcd_out=12'h255; seg_out digits "2","5","5".
- bin_in=7 → bcd_out=12'h007; digits 2,1 = 7'h7F; digit 0 = 7'b1111000. bin_in=0 → digit 0 = 7'b1000000, others blank.
- start=1 held throughout with bin_in=200, changed to 99 at cycle 3 → single done; bcd_out=12'h200. A second done appears only on the re-accepted start, with result 12'h099.
- RESET_N pulsed low at shift cycle 4 of a 255 conversion → busy/done/bcd_out go 0 asynchronously, no done. A new start with 42 → 12'h042 after 8 cycles.
- SIGNED=1, BIN_W=8:
  - 8'h80 → neg=1, bcd_out=12'h128.
  - 8'hFF → neg=1, 12'h001.
  - 8'h7F → neg=0, 12'h127.
- BIN_W=16, DIGITS=5: 16'hFFFF → bcd_out=20'h65535 after 16 cycles. Back-to-back starts give a done every 17 cycles.
